// File: rtl/i2c_reg_seq_if.sv
// Command/status port between the register sequencer and the I2C byte master.
// Command bits: STRT=0 STOP=1 READ=2 WRTE=3 NACK=4; status bits: BSY=0 DON=1 ACK=2 ERR=3 ALO=4 BBL=5 LRA=6.
`ifndef I2C_REG_SEQ_DEFS
`define I2C_REG_SEQ_DEFS
`define C_SZ 5
`define S_SZ 7
`endif

interface i2c_reg_seq_if;
    logic [`C_SZ-1:0] m_cmd;
    logic [7:0]       m_dat;
    logic             m_ws;
    logic [`S_SZ-1:0] m_stat;
    logic [7:0]       m_dat_in;

    modport master (
        output m_cmd, m_dat, m_ws,
        input  m_stat, m_dat_in
    );

    modport slave (
        input  m_cmd, m_dat, m_ws,
        output m_stat, m_dat_in
    );
endinterface

// File: rtl/i2c_reg_seq.sv
// Turns one register read/write request into the I2C byte-master command sequence,
// with ACK checking, error classification and a per-command watchdog.
`ifndef I2C_REG_SEQ_DEFS
`define I2C_REG_SEQ_DEFS
`define C_SZ 5
`define S_SZ 7
`endif

module i2c_reg_seq #(
    parameter int unsigned MAXLEN = 15,
    parameter int unsigned TMO    = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    input  logic                 rnw_i,
    input  logic [6:0]           dev_addr_i,
    input  logic [7:0]           reg_addr_i,
    input  logic [3:0]           len_i,
    input  logic [7:0]           wr_data_i,
    output logic                 wr_take_o,
    output logic [7:0]           rd_data_o,
    output logic                 rd_vld_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2:0]           err_code_o,
    i2c_reg_seq_if.master        mbus_io
);

    localparam int CStrt = 0, CStop = 1, CRead = 2, CWrte = 3, CNack = 4;
    localparam int SBsy = 0, SDon = 1, SAck = 2, SErr = 3, SAlo = 4, SBbl = 5, SLra = 6;

    localparam logic [2:0] StIdle  = 3'd0, StIssue = 3'd1, StSkip = 3'd2, StPoll = 3'd3,
                           StNext  = 3'd4, StAbort = 3'd5, StFin  = 3'd6;
    localparam logic [1:0] PhAddr = 2'd0, PhReg = 2'd1, PhRaddr = 2'd2, PhData = 2'd3;
    localparam logic [3:0] MaxLen = 4'(MAXLEN);

    logic [2:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       k_q, k_d;
    logic [3:0]       len_q, len_d;
    logic             rnw_q, rnw_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic             abort_q, abort_d;
    logic [2:0]       code_q, code_d;
    logic [31:0]      wdog_q, wdog_d;
    logic [`C_SZ-1:0] cmd_q, cmd_d;
    logic [7:0]       dat_q, dat_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_vld_q, rd_vld_d;
    logic             busy_q, busy_d;

    logic [`C_SZ-1:0] step_cmd;
    logic [7:0]       step_dat;
    logic [2:0]       nak_code;
    logic             step_wr, step_stop, last_k, issue;
    logic             unused_stat;

    assign unused_stat = mbus_io.m_stat[SLra];

    // Command and data byte for the current step; an abort overrides with a bare STOP.
    always_comb begin
        step_cmd = '0;
        step_dat = '0;
        nak_code = 3'd1;
        last_k   = (k_q == len_q);
        if (abort_q) begin
            step_cmd[CStop] = 1'b1;
        end else begin
            unique case (phase_q)
                PhAddr: begin
                    step_cmd[CStrt] = 1'b1;
                    step_cmd[CWrte] = 1'b1;
                    step_dat        = {dev_q, 1'b0};
                end
                PhReg: begin
                    step_cmd[CWrte] = 1'b1;
                    step_cmd[CStop] = (len_q == 4'd0);
                    step_dat        = reg_q;
                    nak_code        = 3'd2;
                end
                PhRaddr: begin
                    step_cmd[CStrt] = 1'b1;
                    step_cmd[CWrte] = 1'b1;
                    step_dat        = {dev_q, 1'b1};
                end
                default: begin
                    nak_code = 3'd3;
                    if (rnw_q) begin
                        step_cmd[CRead] = 1'b1;
                        step_cmd[CNack] = last_k;
                        step_cmd[CStop] = last_k;
                    end else begin
                        step_cmd[CWrte] = 1'b1;
                        step_cmd[CStop] = last_k;
                        step_dat        = wr_data_i;
                    end
                end
            endcase
        end
        step_wr   = step_cmd[CWrte];
        step_stop = step_cmd[CStop];
    end

    assign issue            = (state_q == StIssue) && !mbus_io.m_stat[SBsy];
    assign mbus_io.m_ws     = issue;
    assign mbus_io.m_cmd    = issue ? step_cmd : cmd_q;
    assign mbus_io.m_dat    = issue ? step_dat : dat_q;
    assign wr_take_o        = issue && (phase_q == PhData) && !rnw_q && !abort_q;
    assign rd_data_o        = rd_data_q;
    assign rd_vld_o         = rd_vld_q;
    assign busy_o           = busy_q;
    assign done_o           = (state_q == StFin);
    assign err_o            = (code_q != 3'd0);
    assign err_code_o       = code_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        k_d       = k_q;
        len_d     = len_q;
        rnw_d     = rnw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        abort_d   = abort_q;
        code_d    = code_q;
        wdog_d    = wdog_q;
        cmd_d     = cmd_q;
        dat_d     = dat_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        busy_d    = busy_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    rnw_d   = rnw_i;
                    dev_d   = dev_addr_i;
                    reg_d   = reg_addr_i;
                    len_d   = (len_i > MaxLen) ? MaxLen : len_i;
                    phase_d = PhAddr;
                    k_d     = 4'd0;
                    abort_d = 1'b0;
                    code_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (issue) begin
                    cmd_d   = step_cmd;
                    dat_d   = step_dat;
                    state_d = StSkip;
                end
            end
            StSkip: begin
                wdog_d  = '0;
                state_d = StPoll;
            end
            StPoll: begin
                if (!mbus_io.m_stat[SBsy] && mbus_io.m_stat[SDon]) begin
                    if (mbus_io.m_stat[SErr]) begin
                        code_d  = mbus_io.m_stat[SAlo] ? 3'd4 :
                                  mbus_io.m_stat[SBbl] ? 3'd5 : 3'd6;
                        state_d = StFin;
                    end else if (abort_q) begin
                        state_d = StFin;
                    end else if (step_wr && !mbus_io.m_stat[SAck]) begin
                        code_d  = nak_code;
                        abort_d = 1'b1;
                        state_d = StAbort;
                    end else begin
                        state_d = StNext;
                    end
                end else if ((TMO != 0) && (wdog_q == TMO - 1)) begin
                    code_d  = 3'd7;
                    state_d = StFin;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            StNext: begin
                if ((phase_q == PhData) && rnw_q) begin
                    rd_data_d = mbus_io.m_dat_in;
                    rd_vld_d  = 1'b1;
                end
                if (step_stop) begin
                    state_d = StFin;
                end else begin
                    state_d = StIssue;
                    unique case (phase_q)
                        PhAddr:  phase_d = PhReg;
                        PhReg: begin
                            phase_d = rnw_q ? PhRaddr : PhData;
                            k_d     = 4'd1;
                        end
                        PhRaddr: begin
                            phase_d = PhData;
                            k_d     = 4'd1;
                        end
                        default: k_d = k_q + 4'd1;
                    endcase
                end
            end
            StAbort: state_d = StIssue;
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            phase_q   <= PhAddr;
            k_q       <= '0;
            len_q     <= '0;
            rnw_q     <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            abort_q   <= 1'b0;
            code_q    <= '0;
            wdog_q    <= '0;
            cmd_q     <= '0;
            dat_q     <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            k_q       <= k_d;
            len_q     <= len_d;
            rnw_q     <= rnw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            abort_q   <= abort_d;
            code_q    <= code_d;
            wdog_q    <= wdog_d;
            cmd_q     <= cmd_d;
            dat_q     <= dat_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
Register-access sequencer that sits in front of the I2C byte master and drives its command/status port. It turns a single user request into the full command sequence for an I2C register transaction. A write is START+addr/W, register pointer, N data bytes, STOP. A read is START+addr/W, register pointer, repeated START+addr/R, N reads with a NACK on the last, STOP. It handles ACK checking, error classification and a per-command watchdog.

Parameters:
MAXLEN, 15, maximum data bytes per transaction; `len` width is 4 bits.
TMO, 65535, watchdog in clk cycles per issued master command; 0 disables the watchdog.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  1  start a transaction; sampled only in IDLE
rnw  in  1  1 = read, 0 = write; latched with req
dev_addr  in  7  7-bit slave address; latched with req
reg_addr  in  8  register pointer; latched with req
len  in  4  number of data bytes, 0..MAXLEN; latched with req
wr_data  in  8  next write byte; must be valid whenever wr_take can pulse
wr_take  out  1  1-cycle pulse: wr_data consumed this cycle
rd_data  out  8  received byte
rd_vld  out  1  1-cycle pulse: rd_data valid
busy  out  1  transaction in progress
done  out  1  1-cycle pulse at end of transaction, success or error
err  out  1  valid with done; 1 = transaction failed
err_code  out  3  valid with done; held until next req
m_cmd  out  `C_SZ  command to master
m_dat  out  8  data/address byte to master
m_ws  out  1  1-cycle write strobe to master
m_stat  in  `S_SZ  master status (BSY, DON, ACK, ERR, ALO, BBL, LRA)
m_dat_in  in  8  master read-data byte

Behaviour:
- Reset: all outputs 0, state IDLE. The master has its own reset; this block never resets it.
- States: IDLE, ISSUE, SKIP, POLL, NEXT, ABORT, FIN.
- IDLE -> ISSUE on req=1. Latch rnw, dev_addr, reg_addr, len. Set busy=1 and step index s=0.
- ISSUE:
  - Wait until m_stat BSY=0.
  - Then drive m_cmd/m_dat for step s with m_ws=1 for exactly one cycle, and go to SKIP.
  - While BSY=1 in ISSUE, m_ws stays 0.
- SKIP: one cycle, covering the master's registered status update. Arm the watchdog and go to POLL.
- POLL:
  - Wait for BSY=0 and DON=1.
  - Classify errors in priority order: ERR&ALO -> code 4, goto FIN; ERR&BBL -> code 5, FIN; ERR otherwise -> code 6, FIN.
  - Step was a write and ACK=0 -> NAK; go to ABORT. Codes: 1 on an address step, 2 on a register step, 3 on a data step.
  - Otherwise go to NEXT.
  - Watchdog expiry -> code 7, FIN; the block does not attempt a STOP.
- NEXT:
  - On a read-data step: rd_data <= m_dat_in, rd_vld pulse.
  - Step carried STOP -> FIN with err=0, code 0. Else s <= s+1, goto ISSUE.
- ABORT: issue a plain STOP command (ISSUE/SKIP/POLL path, no ACK check), then FIN with the saved NAK code. An error during the abort STOP overrides the code with 4/5/6.
- FIN: done pulse, busy <= 0, goto IDLE. req in the FIN cycle is ignored.
- Write step list:
  - S0 STRT|WRTE, {dev,0}.
  - S1 WRTE, reg; add STOP if len=0.
  - Data step k (k=1..len): WRTE, wr_data, with STOP on k=len. wr_take pulses in the ISSUE cycle that asserts m_ws for that step.
- Read step list:
  - S0 STRT|WRTE, {dev,0}.
  - S1 WRTE, reg; with len=0 this step carries STOP and the sequence ends, a pointer-set only.
  - S2 STRT|WRTE, {dev,1}.
  - Read steps k=1..len: READ, m_dat=0; the last read is READ|NACK|STOP.
- Step and byte counters are 4 bits; the last-step compare is made against latched len; no wrap-around.
- m_cmd/m_dat hold their last values outside m_ws; only m_ws qualifies them.
- rst=1 mid-transaction: immediately IDLE with outputs 0, no done pulse. Any partially issued master command is left to the master.

Test Plan:
- Write dev=0x50 reg=0x10 len=2 data 0xAA,0x55, all ACK -> m_dat sequence A0,10,AA,55; STOP on the 4th command; 2 wr_take pulses; done with err=0.
- Read dev=0x50 reg=0x00 len=3, slave returns 11,22,33 -> commands A0,00,A1, then READ,READ,READ|NACK|STOP; rd_vld x3 with 11,22,33; done with err=0.
- Address NAK on a write -> plain STOP issued; done with err=1, code=1; no wr_take pulses.
- Data NAK on byte 1 of len=3 -> STOP; err code=3; exactly 1 wr_take pulse.
- Master reports ALO during S1 -> no STOP issued; done with err=1, code=4. Bus busy at START -> code=5.
- With TMO=100 and master BSY stuck at 1 after m_ws -> done at 100 cycles with code=7. rst mid-read -> busy=0 next cycle, no done pulse.
